mux_decoded_pipe: RTL

Registered, flow-controlled one-hot/priority way selector for cache and arbitration datapaths. It takes N flattened ways and a decoded select vector, resolves the select to one way index, and queues the chosen entry with its hit status in a 2-entry output buffer. The buffer uses a valid/ready handshake on both sides. A round-robin mode lets the block act as a fair grant-and-mux stage, not only a tag-hit mux.

---
 rtl/mux_decoded_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mux_decoded_pipe.sv
// mux_decoded_pipe: resolves a decoded select vector to one way and queues
// {data, index, hit, multi_hit} in a 2-entry valid/ready output buffer.
// SEL_MODE 0 = lowest set bit wins; SEL_MODE 1 = round-robin from rr_ptr.

// Per-way lane: passes its way entry only when that way holds the grant.
module mux_decoded_pipe_lane #(
    parameter int W = 32
) (
    input  logic [W-1:0] way_data,
    input  logic         grant,
    output logic [W-1:0] gated
);
    assign gated = grant ? way_data : '0;
endmodule

module mux_decoded_pipe #(
    parameter  int NUMBER_WAY                = 8,
    parameter  int SINGLE_ENTRY_SIZE_IN_BITS = 32,
    parameter  int SEL_MODE                  = 0,
    localparam int INDEX_WIDTH               = ($clog2(NUMBER_WAY) > 1) ? $clog2(NUMBER_WAY) : 1
) (
    input  logic                                              clk_in,
    input  logic                                              reset_n_in,
    input  logic                                              request_valid_in,
    output logic                                              request_ready_out,
    input  logic [NUMBER_WAY*SINGLE_ENTRY_SIZE_IN_BITS-1:0]   way_flatted_in,
    input  logic [NUMBER_WAY-1:0]                             sel_in,
    output logic                                              result_valid_out,
    input  logic                                              result_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]              way_flatted_out,
    output logic [INDEX_WIDTH-1:0]                            sel_index_out,
    output logic                                              hit_out,
    output logic                                              multi_hit_out
);
    localparam int N  = NUMBER_WAY;
    localparam int W  = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int IW = INDEX_WIDTH;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] index;
        logic          hit;
        logic          multi_hit;
    } entry_t;

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         low_all;
    logic [IW-1:0]         low_upper;
    logic [IW-1:0]         sel_index;
    logic [N-1:0]          upper_mask;
    logic [N-1:0]          grant;
    logic [N-1:0][W-1:0]   gated;
    logic [W-1:0]          sel_data;
    logic                  hit;
    logic                  multi_hit;
    entry_t                new_entry;

    entry_t [1:0]          mem;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;
    entry_t                head;

    assign hit       = |sel_in;
    assign multi_hit = |(sel_in & (sel_in - N'(1)));

    // Lowest set bit overall, and lowest set bit at or above rr_ptr (descending scan keeps the lowest).
    always_comb begin
        upper_mask = '0;
        low_all    = '0;
        low_upper  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            upper_mask[i] = (IW'(i) >= rr_ptr);
            if (sel_in[i])
                low_all = IW'(i);
            if (sel_in[i] && upper_mask[i])
                low_upper = IW'(i);
        end
    end

    // Round-robin wraps to the lowest set bit when nothing is set at or above the pointer.
    assign sel_index = (SEL_MODE != 0 && (sel_in & upper_mask) != '0) ? low_upper : low_all;

    // One-hot grant from the resolved index; all zero on a miss so data reads 0.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++)
            grant[i] = hit && (sel_index == IW'(i));
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        mux_decoded_pipe_lane #(.W(W)) u_lane (
            .way_data (way_flatted_in[g*W +: W]),
            .grant    (grant[g]),
            .gated    (gated[g])
        );
    end

    // OR-reduce the gated lanes into the selected entry.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            sel_data = sel_data | gated[i];
    end

    assign new_entry = {sel_data, sel_index, hit, multi_hit};

    assign request_ready_out = (count != 2'd2);
    assign result_valid_out  = (count != 2'd0);
    assign push              = request_valid_in && request_ready_out;
    assign pop               = result_valid_out && result_ready_in;

    // Two-entry FIFO storage and pointers; reset drops every buffered entry.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                mem[wr_ptr] <= new_entry;
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Round-robin pointer advances past the granted way on every accepted hit.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in)
            rr_ptr <= '0;
        else if (SEL_MODE != 0 && push && hit)
            rr_ptr <= (sel_index == IW'(N - 1)) ? '0 : sel_index + IW'(1);
    end

    // Head drives the outputs; forced to zero while the buffer is empty.
    assign head            = result_valid_out ? mem[rd_ptr] : '0;
    assign way_flatted_out = head.data;
    assign sel_index_out   = head.index;
    assign hit_out         = head.hit;
    assign multi_hit_out   = head.multi_hit;
endmodule
